// File: rtl/inst_line_responder_pkg.sv
// Shared fetch-side constants and helpers for the instruction line responder.
// The reset PC constants live here so the fetch path agrees on the boot segment.
package inst_line_responder_pkg;

  localparam logic [31:0] PC_INITIAL = 32'hBFC0_0000;
  localparam logic [31:0] PC_EBASE   = 32'hBFC0_0380;

  localparam int unsigned INST_LINE_DEPTH = 4;

  // kseg0/kseg1 both fold onto the same low 512 MiB of physical memory.
  localparam logic [31:0] KSEG_FOLD_MASK = 32'h1FFF_FFFC;
  localparam logic [31:0] WORD_MASK      = 32'hFFFF_FFFC;

  typedef struct packed {
    logic        pending;
    logic [31:0] addr;
  } inst_req_t;

  function automatic logic [31:0] map_inst_addr(input logic [31:0] addr, input bit kseg_map);
    return kseg_map ? (addr & KSEG_FOLD_MASK) : (addr & WORD_MASK);
  endfunction

endpackage

// File: rtl/inst_line_responder_fifo.sv
// Power-of-two synchronous FIFO with optional empty-bypass and optional storage reset.
// rst_i is active-high and must be released synchronously to clk_i.
module inst_line_responder_fifo #(
  parameter int unsigned WIDTH         = 32,
  parameter int unsigned DEEP_SIZE     = 4,
  parameter bit          BYPASS        = 1'b0,
  parameter bit          RETIRE_MEM_EN = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int unsigned PTR_W = $clog2(DEEP_SIZE);

  logic [PTR_W:0]   wptr_q, wptr_d;
  logic [PTR_W:0]   rptr_q, rptr_d;
  logic [WIDTH-1:0] mem_q [DEEP_SIZE];
  logic             stored_empty;
  logic             bypass_hit;
  logic             do_write;
  logic             do_read;

  assign stored_empty = (wptr_q == rptr_q);
  assign full_o       = (wptr_q[PTR_W] != rptr_q[PTR_W]) &&
                        (wptr_q[PTR_W-1:0] == rptr_q[PTR_W-1:0]);

  // With bypass, a push into an empty FIFO is presented on the same cycle.
  assign bypass_hit = BYPASS && stored_empty && push_i;
  assign empty_o    = stored_empty && !bypass_hit;
  assign rdata_o    = bypass_hit ? wdata_i : mem_q[rptr_q[PTR_W-1:0]];

  assign do_write = push_i && !full_o && !(bypass_hit && pop_i);
  assign do_read  = pop_i && !stored_empty;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_write) wptr_d = wptr_q + (PTR_W + 1)'(1);
    if (do_read)  rptr_d = rptr_q + (PTR_W + 1)'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  if (RETIRE_MEM_EN) begin : g_mem_rst
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        mem_q <= '{default: '0};
      end else if (do_write) begin
        mem_q[wptr_q[PTR_W-1:0]] <= wdata_i;
      end
    end
  end else begin : g_mem
    always_ff @(posedge clk_i) begin
      if (do_write) begin
        mem_q[wptr_q[PTR_W-1:0]] <= wdata_i;
      end
    end
  end

  always @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!(push_i && full_o && !(BYPASS && pop_i)));
    end
  end

endmodule

// File: rtl/inst_line_responder.sv
// Responder side of the fetch interface: issues word reads for accepted addresses and
// returns one instruction line per address, in order, with credit-limited buffering.
module inst_line_responder
  import inst_line_responder_pkg::*;
#(
  parameter int unsigned DEPTH    = INST_LINE_DEPTH,
  parameter int unsigned CNT_W    = $clog2(DEPTH + 1),
  parameter bit          KSEG_MAP = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_addr_valid,
  output logic        inst_addr_ready,
  input  logic [31:0] inst_addr,
  output logic        inst_line_valid,
  input  logic        inst_line_ready,
  output logic [31:0] inst_line,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        proto_err
);

  logic [1:0]       rst_sync_q, rst_sync_d;
  logic             rst_released;
  logic             fifo_rst;
  inst_req_t        req_q, req_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] out_q, out_d;
  logic             proto_err_q, proto_err_d;
  logic             addr_accept;
  logic             line_take;
  logic             mem_take;
  logic             rsp_keep;
  logic             rsp_stray;
  logic             fifo_empty;
  logic             fifo_full;

  // Reset asserts everywhere at once but is released to the buffer two edges later.
  always_comb begin
    rst_sync_d = {rst_sync_q[0], 1'b1};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rst_sync_q <= '0;
    end else begin
      rst_sync_q <= rst_sync_d;
    end
  end

  assign rst_released = rst_sync_q[1];
  assign fifo_rst     = ~rst_released;

  assign inst_addr_ready = rst_released & (cnt_q < CNT_W'(DEPTH)) & (~req_q.pending | mem_gnt);
  assign inst_line_valid = ~fifo_empty;
  assign mem_req         = req_q.pending;
  assign mem_addr        = req_q.addr;
  assign proto_err       = proto_err_q;

  assign addr_accept = inst_addr_valid & inst_addr_ready;
  assign line_take   = inst_line_valid & inst_line_ready;
  assign mem_take    = req_q.pending & mem_gnt;
  assign rsp_keep    = mem_rvalid & (out_q != '0);
  assign rsp_stray   = mem_rvalid & (out_q == '0);

  always_comb begin
    req_d = req_q;
    if (addr_accept) begin
      req_d.pending = 1'b1;
      req_d.addr    = map_inst_addr(inst_addr, KSEG_MAP);
    end else if (mem_take) begin
      req_d.pending = 1'b0;
    end
  end

  // Credits cover every address until its line is consumed, so the buffer never overflows.
  always_comb begin
    cnt_d = cnt_q;
    if (addr_accept && !line_take) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (!addr_accept && line_take) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_comb begin
    out_d = out_q;
    if (mem_take && !rsp_keep) begin
      out_d = out_q + CNT_W'(1);
    end else if (!mem_take && rsp_keep) begin
      out_d = out_q - CNT_W'(1);
    end
  end

  always_comb begin
    proto_err_d = proto_err_q | rsp_stray;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_q       <= '0;
      cnt_q       <= '0;
      out_q       <= '0;
      proto_err_q <= 1'b0;
    end else begin
      req_q       <= req_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
      proto_err_q <= proto_err_d;
    end
  end

  inst_line_responder_fifo #(
    .WIDTH        (32),
    .DEEP_SIZE    (DEPTH),
    .BYPASS       (1'b0),
    .RETIRE_MEM_EN(1'b0)
  ) u_ret_buf (
    .clk_i  (clk),
    .rst_i  (fifo_rst),
    .push_i (rsp_keep),
    .wdata_i(mem_rdata),
    .pop_i  (line_take),
    .rdata_o(inst_line),
    .empty_o(fifo_empty),
    .full_o (fifo_full)
  );

  always @(posedge clk) begin
    if (rst_released) begin
      assert (!(addr_accept && !line_take && cnt_q == CNT_W'(DEPTH)));
      assert (!(line_take && !addr_accept && cnt_q == '0));
      assert (!(mem_take && !rsp_keep && out_q == CNT_W'(DEPTH)));
      assert (!(rsp_keep && fifo_full));
    end
  end

endmodule

// File: tb/tb_inst_line_responder.sv
// Directed and randomized checks of inst_line_responder against a queue-based memory and
// fetch model; one procedural thread drives inputs at negedge and samples just after.
module tb_inst_line_responder;

  logic        clk;
  logic        rst;
  logic        inst_addr_valid;
  logic        inst_addr_ready;
  logic [31:0] inst_addr;
  logic        inst_line_valid;
  logic        inst_line_ready;
  logic [31:0] inst_line;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        proto_err;

  inst_line_responder #(
    .DEPTH   (4),
    .CNT_W   (3),
    .KSEG_MAP(1'b1)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .inst_addr_valid(inst_addr_valid),
    .inst_addr_ready(inst_addr_ready),
    .inst_addr      (inst_addr),
    .inst_line_valid(inst_line_valid),
    .inst_line_ready(inst_line_ready),
    .inst_line      (inst_line),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_gnt        (mem_gnt),
    .mem_rvalid     (mem_rvalid),
    .mem_rdata      (mem_rdata),
    .proto_err      (proto_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int nvec;
  int nfail;
  int cyc;
  logic [31:0] addr_src_q[$];
  logic [31:0] exp_gnt_q[$];
  logic [31:0] exp_line_q[$];
  logic [31:0] mem_data_q[$];
  int          mem_due_q[$];
  int          acc_cyc_q[$];
  int          line_cyc_q[$];
  int credit, max_credit, model_out, n_stall, gnt_wait, last_due, mem_delay_max;
  bit model_perr, stray_pend, gnt_rand, lr_rand, valid_rand, lr_fixed;
  logic rdy_s;

  // Memory contents: a fixed scramble of the word address.
  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return {a[15:0] ^ 16'h2408, a[31:16] ^ 16'h1FC1};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: entered and left at negedge.
  task automatic step();
    logic [31:0] a;
    int d;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    if (stray_pend) begin
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hDEAD_BEEF;
      stray_pend = 1'b0;
    end else if (mem_due_q.size() > 0 && mem_due_q[0] <= cyc) begin
      mem_rvalid = 1'b1;
      mem_rdata  = mem_data_q.pop_front();
      void'(mem_due_q.pop_front());
    end
    mem_gnt         = gnt_rand ? (gnt_wait == 0) : 1'b1;
    inst_line_ready = lr_rand ? 1'($urandom_range(0, 1)) : lr_fixed;
    inst_addr_valid = (addr_src_q.size() > 0) && (!valid_rand || $urandom_range(0, 3) != 0);
    inst_addr       = inst_addr_valid ? addr_src_q[0] : $urandom();
    #1;
    rdy_s = inst_addr_ready;
    chk("proto_err", 32'(proto_err), 32'(model_perr));
    if (inst_line_valid && inst_line_ready) begin
      if (exp_line_q.size() == 0) begin
        chk("line_pending", 32'(exp_line_q.size()), 1);
      end else begin
        chk("line", inst_line, exp_line_q.pop_front());
        credit--;
        line_cyc_q.push_back(cyc);
      end
    end
    if (mem_rvalid) begin
      if (model_out > 0) model_out--;
      else model_perr = 1'b1;
    end
    if (mem_req && mem_gnt) begin
      if (exp_gnt_q.size() == 0) chk("gnt_pending", 32'(exp_gnt_q.size()), 1);
      else chk("mem_addr", mem_addr, exp_gnt_q.pop_front());
      d = cyc + int'($urandom_range(1, mem_delay_max));
      if (d <= last_due) d = last_due + 1;
      last_due = d;
      mem_data_q.push_back(mem_fn(mem_addr));
      mem_due_q.push_back(d);
      model_out++;
      if (gnt_rand) gnt_wait = int'($urandom_range(0, 5));
    end else if (gnt_wait > 0) begin
      gnt_wait--;
    end
    if (inst_addr_valid && inst_addr_ready) begin
      a = addr_src_q.pop_front();
      exp_gnt_q.push_back(a & 32'h1FFF_FFFC);
      exp_line_q.push_back(mem_fn(a & 32'h1FFF_FFFC));
      credit++;
      acc_cyc_q.push_back(cyc);
    end else if (inst_addr_valid) begin
      n_stall++;
    end
    if (credit > max_credit) max_credit = credit;
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic wait_ready(input string tag);
    int k;
    k = 0;
    rdy_s = 1'b0;
    while (!rdy_s && k < 20) begin
      step();
      k++;
    end
    chk(tag, 32'(rdy_s), 1);
  endtask

  task automatic drain(input string tag, input int budget);
    int k;
    k = 0;
    while ((addr_src_q.size() > 0 || exp_line_q.size() > 0) && k < budget) begin
      step();
      k++;
    end
    chk(tag, 32'(exp_line_q.size() + addr_src_q.size()), 0);
  endtask

  task automatic single_fetch(input string tag, input logic [31:0] a);
    int k;
    k = 0;
    acc_cyc_q.delete();
    line_cyc_q.delete();
    addr_src_q.push_back(a);
    while (line_cyc_q.size() == 0 && k < 30) begin
      step();
      k++;
    end
    chk({tag, "_seen"}, 32'(line_cyc_q.size()), 1);
    if (line_cyc_q.size() == 1 && acc_cyc_q.size() == 1) begin
      chk({tag, "_latency"}, 32'(line_cyc_q[0] - acc_cyc_q[0]), 3);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_addr_ready"}, 32'(inst_addr_ready), 0);
    chk({tag, "_line_valid"}, 32'(inst_line_valid), 0);
    chk({tag, "_mem_req"}, 32'(mem_req), 0);
    chk({tag, "_mem_addr"}, mem_addr, 32'h0);
    chk({tag, "_proto_err"}, 32'(proto_err), 0);
  endtask

  initial begin
    nvec = 0; nfail = 0; cyc = 0;
    credit = 0; max_credit = 0; model_out = 0; n_stall = 0; gnt_wait = 0; last_due = 0;
    mem_delay_max = 1;
    model_perr = 1'b0; stray_pend = 1'b0; gnt_rand = 1'b0; lr_rand = 1'b0; valid_rand = 1'b0;
    lr_fixed = 1'b1;
    inst_addr_valid = 1'b0; inst_addr = 32'h0; inst_line_ready = 1'b0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;

    rst = 1'b1;
    #1 rst = 1'b0;
    @(negedge clk);
    #1;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b1;
    wait_ready("ready_after_reset");

    // Boot fetch: kseg1 address folds to physical 0x1FC0_0000.
    single_fetch("single", 32'hBFC0_0000);
    chk("single_data_model", mem_fn(32'h1FC0_0000), 32'h2408_0001);

    // Back-to-back: eight addresses, one per cycle in and out.
    acc_cyc_q.delete();
    line_cyc_q.delete();
    n_stall = 0;
    for (int i = 0; i < 8; i++) addr_src_q.push_back(32'h8000_1000 + 32'(i * 4));
    drain("b2b_drain", 60);
    chk("b2b_stalls", 32'(n_stall), 0);
    chk("b2b_lines", 32'(line_cyc_q.size()), 8);
    if (acc_cyc_q.size() == 8 && line_cyc_q.size() == 8) begin
      chk("b2b_acc_span", 32'(acc_cyc_q[7] - acc_cyc_q[0]), 7);
      chk("b2b_line_span", 32'(line_cyc_q[7] - line_cyc_q[0]), 7);
    end

    // Backpressure: credits run out at DEPTH, one pop frees exactly one slot.
    lr_fixed = 1'b0;
    acc_cyc_q.delete();
    for (int i = 0; i < 10; i++) addr_src_q.push_back(32'hA000_2000 + 32'(i * 4 + i % 4));
    repeat (12) step();
    chk("bp_accepts", 32'(acc_cyc_q.size()), 4);
    chk("bp_ready_low", 32'(rdy_s), 0);
    lr_fixed = 1'b1;
    step();
    lr_fixed = 1'b0;
    repeat (8) step();
    chk("bp_one_more", 32'(acc_cyc_q.size()), 5);
    chk("bp_ready_low2", 32'(rdy_s), 0);
    lr_fixed = 1'b1;
    drain("bp_drain", 100);

    // Random grant stalls, response gaps, consumer stalls and address gaps.
    gnt_rand = 1'b1; lr_rand = 1'b1; valid_rand = 1'b1; mem_delay_max = 4;
    max_credit = 0;
    line_cyc_q.delete();
    for (int i = 0; i < 1000; i++) addr_src_q.push_back($urandom());
    drain("rand_drain", 30000);
    chk("rand_lines", 32'(line_cyc_q.size()), 1000);
    chk("rand_max_credit_le_4", 32'(max_credit <= 4), 1);
    gnt_rand = 1'b0; lr_rand = 1'b0; valid_rand = 1'b0; lr_fixed = 1'b1; mem_delay_max = 1;

    // Stray response with nothing outstanding.
    repeat (2) step();
    stray_pend = 1'b1;
    step();
    repeat (3) step();
    chk("stray_line_valid", 32'(inst_line_valid), 0);
    chk("stray_proto_err", 32'(proto_err), 1);

    // Reset with three lines buffered.
    lr_fixed = 1'b0;
    for (int i = 0; i < 3; i++) addr_src_q.push_back(32'h9FC0_0100 + 32'(i * 4));
    repeat (8) step();
    chk("pre_rst_line_valid", 32'(inst_line_valid), 1);
    #2 rst = 1'b0;
    #1;
    chk_reset_outputs("mid_reset");
    addr_src_q.delete(); exp_gnt_q.delete(); exp_line_q.delete();
    mem_data_q.delete(); mem_due_q.delete();
    model_out = 0; credit = 0; model_perr = 1'b0; stray_pend = 1'b0; last_due = 0;
    inst_addr_valid = 1'b0; mem_rvalid = 1'b0; mem_gnt = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_hold_proto_err", 32'(proto_err), 0);
    rst = 1'b1;
    lr_fixed = 1'b1;
    wait_ready("ready_after_reset2");
    single_fetch("post_rst", 32'h8000_0124);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/inst_line_responder.md
Name: inst_line_responder

Overview:
- Responder end of the fetch-instruction interface. Accepts instruction addresses on the inst_addr valid/ready channel and issues aligned word reads to the instruction memory port.
- Returns exactly one 32-bit inst_line per accepted address, strictly in acceptance order, on the inst_line valid/ready channel.
- Sits between inst_fetch and the instruction SRAM/cache bus. Credit-limits accepted addresses so every in-flight response is guaranteed buffer space.

Parameters:
- DEPTH, 4, maximum addresses accepted but not yet returned on inst_line; also the return-buffer depth (power of two, ≥2).
- CNT_W, 3, width of the credit counter; must hold 0..DEPTH, i.e. $clog2(DEPTH+1).
- KSEG_MAP, 1, 1: mem_addr = {3'b000, addr[28:2], 2'b00} (kseg0/kseg1 fold); 0: mem_addr = {addr[31:2], 2'b00}.

Ports:
- clk  in  1  clock, all state on posedge.
- rst  in  1  asynchronous reset, active-low (0 = reset).
- inst_addr_valid  in  1  fetch address valid.
- inst_addr_ready  out  1  address accepted when valid&ready.
- inst_addr  in  32  fetch address; bits [1:0] are ignored.
- inst_line_valid  out  1  returned instruction valid.
- inst_line_ready  in  1  consumer takes the line when valid&ready.
- inst_line  out  32  instruction word.
- mem_req  out  1  memory read request.
- mem_addr  out  32  word-aligned memory address.
- mem_gnt  in  1  request accepted this cycle.
- mem_rvalid  in  1  read data valid. In order, one per granted request, no backpressure.
- mem_rdata  in  32  read data.
- proto_err  out  1  sticky flag: mem_rvalid arrived with no outstanding request.

Behaviour:
- Reset (rst=0, async): inst_addr_ready=0, inst_line_valid=0, mem_req=0, mem_addr=0, proto_err=0. Credit counter, outstanding counter and return buffer are cleared. Reset mid-operation discards all in-flight state; the memory is reset together with this block, so no stale rvalid follows.
- Request register: holds one pending request (req_pending, req_addr).
- Credit counter cnt counts addresses accepted whose line has not yet been taken on inst_line.
  - +1 on address accept, −1 on line handshake; both in the same cycle leaves cnt unchanged.
  - Range 0..DEPTH. Overflow or underflow is an assertion failure.
- inst_addr_ready = rst_released & (cnt < DEPTH) & (~req_pending | mem_gnt). This is combinational and does not depend on inst_addr_valid.
- Address accept at edge N: req_pending=1 and mem_addr=mapped address, both visible in cycle N+1. mem_req = req_pending.
  - mem_gnt while mem_req=1 clears req_pending, unless a new address is accepted in the same cycle, in which case the new request is loaded.
  - Sustained throughput with mem_gnt tied high: 1 address/cycle.
- Outstanding counter: +1 on mem_req&mem_gnt, −1 on mem_rvalid. Bound DEPTH.
- mem_rvalid with outstanding=0: data is dropped and proto_err is set (sticky until reset).
- mem_rvalid with outstanding>0: mem_rdata is written to the return buffer. Buffer space is guaranteed by the credit rule, so a full-buffer write is an assertion failure.
- inst_line_valid = return buffer non-empty. inst_line = buffer head. The buffer pops on inst_line_valid&inst_line_ready.
- Data written at edge M is visible as inst_line in cycle M+1 (no bypass).
- Minimum latency, with gnt immediate and rvalid one cycle after gnt: accept at edge N, line valid in cycle N+3.
- Order: lines are returned strictly FIFO. No reordering, no flush input. The initiator discards unwanted lines itself.
- Misaligned inst_addr (bits [1:0]≠0): treated as a normal request to the aligned word. The initiator raises the exception.

Decomposition:
- Shared package/header entries: DEPTH default and the KSEG fold mask, defined alongside the existing PC_INITIAL/PC_EBASE constants.
- Return buffer: instantiate the existing fifo module with WIDTH=32, DEEP_SIZE=DEPTH, BYPASS=0, RETIRE_MEM_EN=0. Drive its reset from ~rst, resynchronised as required by fifo.
- Request register, both counters and the mapping logic live in this module.

Test Plan:
- Single fetch: addr 32'hBFC0_0000, gnt immediate, rvalid next cycle with data 32'h2408_0001 → mem_addr=32'h1FC0_0000, line 32'h2408_0001 valid exactly 3 cycles after accept.
- Back-to-back: 8 consecutive addresses, gnt=1, rvalid 1 cycle later, line_ready=1 → ready stays high, 8 lines returned in issue order, 1/cycle.
- Backpressure: line_ready=0, DEPTH=4 → after 4 accepts inst_addr_ready=0; one pop re-enables exactly one accept; no data lost.
- Random gnt stalls (0–5 cycles) and random rvalid gaps over 1000 addresses → returned lines match the address scoreboard in order; cnt never exceeds 4.
- Stray rvalid with no outstanding request → data not written, inst_line_valid stays 0, proto_err=1 until reset.
- Assert rst=0 with 3 requests in flight, release after 2 cycles → all outputs at reset values immediately; first subsequent fetch returns correct data.
